// File: rtl/exu_pkg.sv
// Shared types and constants for the execute stage.
// Holds ALU/FD/FGS codes, flag bit indices and the ID/EX and EX/MEM bus layouts.
package exu_pkg;

  localparam int IDEX_W  = 91;
  localparam int EXMEM_W = 76;

  // Field offsets on the ID/EX bus
  localparam int IDEX_DATA1_LSB = 9;
  localparam int IDEX_DATA2_LSB = 25;
  localparam int IDEX_PC_LSB    = 52;

  // Field offsets on the EX/MEM bus
  localparam int EXMEM_DATA_LSB  = 0;
  localparam int EXMEM_ADDR_LSB  = 38;
  localparam int EXMEM_FLAGS_LSB = 73;

  // Flag register bit positions: {NF,CF,ZF}
  localparam int F_NF = 2;
  localparam int F_CF = 1;
  localparam int F_ZF = 0;

  // Two-operand ALU codes (OPS=0)
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd7;

  // One-operand ALU codes (OPS=1)
  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_DEC = 3'd1;

  typedef enum logic [1:0] {
    FD_NOP  = 2'b00,
    FD_SETC = 2'b01,
    FD_MOV  = 2'b10,
    FD_ALU  = 2'b11
  } fd_e;

  typedef enum logic [1:0] {
    FGS_ALW = 2'b00,
    FGS_ZF  = 2'b01,
    FGS_NF  = 2'b10,
    FGS_CF  = 2'b11
  } fgs_e;

  // MSB-first; bit positions noted on the right
  typedef struct packed {
    logic        stack_flags; // 90
    logic        stack_pc;    // 89
    logic        imm;         // 88
    logic [2:0]  src;         // 87:85
    logic        jwsp;        // 84
    logic [31:0] pc;          // 83:52
    fgs_e        fgs;         // 51:50
    logic        spop;        // 49
    logic        sp;          // 48
    logic        jmp;         // 47
    logic        wb;          // 46
    logic        mw;          // 45
    logic        mr;          // 44
    logic [2:0]  wb_addr;     // 43:41
    logic [15:0] data2;       // 40:25
    logic [15:0] data1;       // 24:9
    fd_e         fd;          // 8:7
    logic        alu;         // 6
    logic [2:0]  alu_op;      // 5:3
    logic        ops;         // 2
    logic        iow;         // 1
    logic        ior;         // 0
  } id_ex_t;

  typedef struct packed {
    logic [2:0]  final_flags; // 75:73
    logic        stack_flags; // 72
    logic        stack_pc;    // 71
    logic        jwsp;        // 70
    logic [31:0] address;     // 69:38
    logic        wb;          // 37
    logic        mw;          // 36
    logic        mr;          // 35
    logic [2:0]  wb_addr;     // 34:32
    logic [31:0] data;        // 31:0
  } ex_mem_t;

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'b0, v};
  endfunction

endpackage

// File: rtl/alu16.sv
// 16-bit combinational ALU with {NF,CF,ZF} flag generation.
// Ports: a,b operands; op/ops select; flags_in current flags; res, flags_out. Shifts need EXU_SHIFT_EN.
module alu16
  import exu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  op,
  input  logic        ops,
  input  logic [2:0]  flags_in,
  output logic [15:0] res,
  output logic [2:0]  flags_out
);

  logic [16:0] sum;
  logic        cf;
  logic        upd;
`ifdef EXU_SHIFT_EN
  logic [4:0]  n;
  logic [31:0] wl;
  logic [31:0] wr;
`endif

  always_comb begin
    res = a;
    sum = '0;
    cf  = flags_in[F_CF];
    upd = 1'b1;
`ifdef EXU_SHIFT_EN
    n  = b[4:0];
    // Widened shifts: bit 16 / bit 15 is the last bit shifted out,
    // and naturally reads 0 once the amount exceeds 16.
    wl = {16'b0, a} << n;
    wr = {a, 16'b0} >> n;
`endif
    if (ops) begin
      case (op)
        OP_INC: begin
          sum = {1'b0, a} + 17'd1;
          res = sum[15:0];
          cf  = sum[16];
        end
        OP_DEC: begin
          sum = {1'b0, a} - 17'd1;
          res = sum[15:0];
          cf  = sum[16];
        end
        OP_NOT: res = ~a;
        default: res = a;
      endcase
    end else begin
      case (op)
        OP_ADD: begin
          sum = {1'b0, a} + {1'b0, b};
          res = sum[15:0];
          cf  = sum[16];
        end
        OP_SUB: begin
          sum = {1'b0, a} - {1'b0, b};
          res = sum[15:0];
          cf  = sum[16];
        end
        OP_AND: res = a & b;
        OP_OR:  res = a | b;
        OP_NOT: res = ~a;
`ifdef EXU_SHIFT_EN
        OP_SHL: begin
          res = wl[15:0];
          if (n != 5'd0) cf = wl[16];
        end
        OP_SHR: begin
          res = wr[31:16];
          if (n != 5'd0) cf = wr[15];
        end
`else
        OP_SHL: upd = 1'b0;
        OP_SHR: upd = 1'b0;
`endif
        default: res = a;
      endcase
    end
    if (upd) begin
      flags_out = {res[15], cf, (res == 16'd0)};
    end else begin
      flags_out = flags_in;
    end
  end

endmodule

// File: rtl/execution_unit.sv
// Execute stage: ALU, MOV/IN/OUT data select, stack addressing, jump resolution.
// In: clk, reset, ID_EX, operands/forwarding, SP. Out: EX_MEM, Flags, SP out, jump. Option: EXU_SHIFT_EN.
module execution_unit
  import exu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [90:0] ID_EX,
  input  logic [15:0] Immediate_Value,
  input  logic [1:0]  Fwd_Sel,
  input  logic [15:0] Fwd_Data1,
  input  logic [15:0] Fwd_Data2,
  input  logic [2:0]  Flags_From_Memory,
  input  logic [15:0] INPUT_PORT,
  input  logic [31:0] Stack_Pointer,
  output logic [75:0] EX_MEM,
  output logic [2:0]  Flags,
  output logic [31:0] Stack_Pointer_Out,
  output logic        Taken_Jump,
  output logic        To_PC_Selector
);

  id_ex_t      ie;
  ex_mem_t     em_d;
  ex_mem_t     em_q;
  logic [2:0]  flags_q;
  logic [2:0]  nxt;
  logic [2:0]  alu_flags;
  logic [15:0] alu_res;
  logic [15:0] a_op;
  logic [15:0] d2_op;
  logic [15:0] b_op;
  logic        taken;
  logic        unused_src;

  assign ie = id_ex_t'(ID_EX);
  assign unused_src = ^ie.src;

  assign a_op  = Fwd_Sel[0] ? Fwd_Data1 : ie.data1;
  assign d2_op = Fwd_Sel[1] ? Fwd_Data2 : ie.data2;
  assign b_op  = ie.imm ? Immediate_Value : d2_op;

  alu16 u_alu (
    .a         (a_op),
    .b         (b_op),
    .op        (ie.alu_op),
    .ops       (ie.ops),
    .flags_in  (flags_q),
    .res       (alu_res),
    .flags_out (alu_flags)
  );

  // Next flags: ALU/SETC/CLRC, then jump clearing, then stack pop restore
  always_comb begin
    nxt   = flags_q;
    taken = 1'b0;
    if (ie.alu && ie.fd == FD_ALU) begin
      nxt = alu_flags;
    end else if (!ie.alu && ie.fd == FD_SETC) begin
      nxt[F_CF] = 1'b1;
    end else if (ie.alu && ie.fd == FD_NOP) begin
      nxt[F_CF] = 1'b0;
    end
    if (ie.jmp) begin
      case (ie.fgs)
        FGS_ALW: taken = 1'b1;
        FGS_ZF: if (flags_q[F_ZF]) begin
          taken     = 1'b1;
          nxt[F_ZF] = 1'b0;
        end
        FGS_NF: if (flags_q[F_NF]) begin
          taken     = 1'b1;
          nxt[F_NF] = 1'b0;
        end
        FGS_CF: if (flags_q[F_CF]) begin
          taken     = 1'b1;
          nxt[F_CF] = 1'b0;
        end
        default: taken = 1'b0;
      endcase
    end
    if (ie.sp && ie.spop && ie.stack_flags) begin
      nxt = Flags_From_Memory;
    end
  end

  always_comb begin
    em_d = '0;
    if (ie.stack_pc) begin
      em_d.data = ie.pc;
    end else if (ie.ior) begin
      em_d.data = zext16(INPUT_PORT);
    end else if (ie.iow) begin
      em_d.data = zext16(a_op);
    end else if (ie.fd == FD_ALU) begin
      em_d.data = zext16(alu_res);
    end else if (ie.fd == FD_MOV) begin
      em_d.data = zext16(b_op);
    end else begin
      em_d.data = zext16(a_op);
    end
    if (ie.sp) begin
      em_d.address = ie.spop ? Stack_Pointer + 32'd1
                             : Stack_Pointer;
    end else begin
      em_d.address = zext16(a_op);
    end
    em_d.wb_addr     = ie.wb_addr;
    em_d.mr          = ie.mr;
    em_d.mw          = ie.mw;
    em_d.wb          = ie.wb;
    em_d.jwsp        = ie.jwsp;
    em_d.stack_pc    = ie.stack_pc;
    em_d.stack_flags = ie.stack_flags;
    em_d.final_flags = nxt;
  end

  always_comb begin
    Stack_Pointer_Out = Stack_Pointer;
    if (ie.sp) begin
      Stack_Pointer_Out = ie.spop ? Stack_Pointer + 32'd1
                                  : Stack_Pointer - 32'd1;
    end
  end

  assign Taken_Jump     = taken;
  assign To_PC_Selector = taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
      em_q    <= '0;
    end else begin
      flags_q <= nxt;
      em_q    <= em_d;
    end
  end

  assign EX_MEM = em_q;
  assign Flags  = flags_q;

endmodule

// File: tb/tb_execution_unit.sv
// Directed self-checking bench for execution_unit.
// Shift expectations follow EXU_SHIFT_EN.
module tb_execution_unit;
  import exu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  id_ex_t      ie;
  logic [15:0] imm_v;
  logic [1:0]  fsel;
  logic [15:0] fd1;
  logic [15:0] fd2;
  logic [2:0]  ffm;
  logic [15:0] in_port;
  logic [31:0] sp;
  logic [75:0] em_w;
  ex_mem_t     em;
  logic [2:0]  flags;
  logic [31:0] sp_out;
  logic        tj;
  logic        tpc;

  int n_cmp = 0;
  int n_bad = 0;

  assign em = ex_mem_t'(em_w);

  always #5 clk = ~clk;

  execution_unit dut (
    .clk               (clk),
    .reset             (reset),
    .ID_EX             (ie),
    .Immediate_Value   (imm_v),
    .Fwd_Sel           (fsel),
    .Fwd_Data1         (fd1),
    .Fwd_Data2         (fd2),
    .Flags_From_Memory (ffm),
    .INPUT_PORT        (in_port),
    .Stack_Pointer     (sp),
    .EX_MEM            (em_w),
    .Flags             (flags),
    .Stack_Pointer_Out (sp_out),
    .Taken_Jump        (tj),
    .To_PC_Selector    (tpc)
  );

  task automatic chk(input string tag,
                     input logic [75:0] obs,
                     input logic [75:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic alu_op(input logic ops, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b);
    ie        = '0;
    ie.alu    = 1'b1;
    ie.fd     = FD_ALU;
    ie.ops    = ops;
    ie.alu_op = op;
    ie.data1  = a;
    ie.data2  = b;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ie = '0; imm_v = '0; fsel = '0; fd1 = '0; fd2 = '0;
    ffm = '0; in_port = '0; sp = '0;
    #2;
    alu_op(1'b0, OP_ADD, 16'd7, 16'd8);
    edge_wait();
    chk("rst_exmem", em_w, 76'd0);
    chk("rst_flags", flags, 3'b000);

    @(negedge clk);
    reset = 1'b0;
    ie = '0;
    edge_wait();
    chk("idle_exmem", em_w, 76'd0);

    // MOV
    @(negedge clk);
    ie = '0; ie.fd = FD_MOV; ie.data2 = 16'd127;
    ie.wb_addr = 3'd7; ie.wb = 1'b1;
    edge_wait();
    chk("mov_data", em.data, 32'd127);
    chk("mov_wbaddr", em.wb_addr, 3'd7);
    chk("mov_wb", em.wb, 1'b1);
    chk("mov_flags", flags, 3'b000);

    @(negedge clk); alu_op(1'b0, OP_ADD, 16'd7, 16'd8);
    edge_wait();
    chk("add_data", em.data, 32'd15);
    chk("add_addr", em.address, 32'd7);
    chk("add_flags", flags, 3'b000);

    @(negedge clk); alu_op(1'b0, OP_SUB, 16'd8, 16'd23);
    edge_wait();
    chk("sub_data", em.data, 32'h0000_FFF1);
    chk("sub_flags", flags, 3'b110);
    chk("sub_ff", em.final_flags, 3'b110);

    @(negedge clk); alu_op(1'b0, OP_AND, 16'hF0F0, 16'h0F0F);
    edge_wait();
    chk("and_data", em.data, 32'd0);
    chk("and_flags", flags, 3'b011);

    // Shifts with immediate operand
    @(negedge clk); alu_op(1'b0, OP_SHL, 16'hFFFF, 16'd0);
    ie.imm = 1'b1; imm_v = 16'd16;
    edge_wait();
`ifdef EXU_SHIFT_EN
    chk("shl16_data", em.data, 32'd0);
    chk("shl16_flags", flags, 3'b011);
`else
    chk("shl16_data", em.data, 32'h0000_FFFF);
    chk("shl16_flags", flags, 3'b011);
`endif

    @(negedge clk); alu_op(1'b0, OP_SHL, 16'hFFFF, 16'd0);
    ie.imm = 1'b1; imm_v = 16'd15;
    edge_wait();
`ifdef EXU_SHIFT_EN
    chk("shl15_data", em.data, 32'h0000_8000);
    chk("shl15_flags", flags, 3'b110);
`else
    chk("shl15_data", em.data, 32'h0000_FFFF);
    chk("shl15_flags", flags, 3'b011);
`endif

    @(negedge clk); alu_op(1'b0, OP_SHR, 16'hFFFF, 16'd0);
    ie.imm = 1'b1; imm_v = 16'd15;
    edge_wait();
`ifdef EXU_SHIFT_EN
    chk("shr15_data", em.data, 32'd1);
    chk("shr15_flags", flags, 3'b010);
`else
    chk("shr15_data", em.data, 32'h0000_FFFF);
    chk("shr15_flags", flags, 3'b011);
`endif

    @(negedge clk); alu_op(1'b0, OP_SHL, 16'hFFFF, 16'd0);
    ie.imm = 1'b1; imm_v = 16'd0;
    edge_wait();
`ifdef EXU_SHIFT_EN
    chk("shl0_data", em.data, 32'h0000_FFFF);
    chk("shl0_flags", flags, 3'b110);
`else
    chk("shl0_data", em.data, 32'h0000_FFFF);
    chk("shl0_flags", flags, 3'b011);
`endif

    @(negedge clk); alu_op(1'b0, OP_SHL, 16'hFFFF, 16'd0);
    ie.imm = 1'b1; imm_v = 16'd20;
    edge_wait();
`ifdef EXU_SHIFT_EN
    chk("shl20_data", em.data, 32'd0);
    chk("shl20_flags", flags, 3'b001);
`else
    chk("shl20_data", em.data, 32'h0000_FFFF);
    chk("shl20_flags", flags, 3'b011);
`endif

    @(negedge clk); alu_op(1'b1, OP_INC, 16'd7, 16'd0); imm_v = '0;
    edge_wait();
    chk("inc_data", em.data, 32'd8);
    chk("inc_flags", flags, 3'b000);

    @(negedge clk); alu_op(1'b1, OP_INC, 16'hFFFF, 16'd0);
    edge_wait();
    chk("incw_data", em.data, 32'd0);
    chk("incw_flags", flags, 3'b011);

    @(negedge clk); alu_op(1'b1, OP_DEC, 16'd7, 16'd0);
    edge_wait();
    chk("dec_data", em.data, 32'd6);
    chk("dec_flags", flags, 3'b000);

    @(negedge clk); alu_op(1'b1, OP_DEC, 16'd0, 16'd0);
    edge_wait();
    chk("dec0_data", em.data, 32'h0000_FFFF);
    chk("dec0_flags", flags, 3'b110);

    @(negedge clk); alu_op(1'b1, OP_NOT, 16'd15, 16'd0);
    edge_wait();
    chk("not_data", em.data, 32'h0000_FFF0);
    chk("not_flags", flags, 3'b110);

    // CLRC / SETC / NOP
    @(negedge clk);
    ie = '0; ie.alu = 1'b1; ie.fd = FD_NOP; ie.data1 = 16'h0022;
    edge_wait();
    chk("clrc_flags", flags, 3'b100);
    chk("clrc_data", em.data, 32'h22);

    @(negedge clk); ie = '0; ie.fd = FD_SETC;
    edge_wait();
    chk("setc_flags", flags, 3'b110);

    @(negedge clk); ie = '0;
    edge_wait();
    chk("nop_flags", flags, 3'b110);

    // Forwarded operands
    @(negedge clk); alu_op(1'b0, OP_ADD, 16'h1111, 16'h2222);
    fsel = 2'b11; fd1 = 16'h1000; fd2 = 16'h0234;
    edge_wait();
    chk("fwd_data", em.data, 32'h1234);
    chk("fwd_flags", flags, 3'b000);

    @(negedge clk); alu_op(1'b0, OP_NOT, 16'h00FF, 16'hAAAA); fsel = '0;
    edge_wait();
    chk("not2_data", em.data, 32'h0000_FF00);
    chk("not2_flags", flags, 3'b100);

    @(negedge clk); alu_op(1'b0, OP_OR, 16'h8000, 16'h0001);
    edge_wait();
    chk("or_data", em.data, 32'h0000_8001);
    chk("or_flags", flags, 3'b100);

    @(negedge clk);
    ie = '0; ie.ior = 1'b1; ie.data1 = 16'h0077; in_port = 16'hBEEF;
    edge_wait();
    chk("in_data", em.data, 32'h0000_BEEF);
    chk("in_flags", flags, 3'b100);

    @(negedge clk);
    ie = '0; ie.iow = 1'b1; ie.fd = FD_ALU;
    ie.data1 = 16'h0055; ie.data2 = 16'h0099;
    edge_wait();
    chk("out_data", em.data, 32'h55);
    chk("out_flags", flags, 3'b100);

    // Stack
    @(negedge clk);
    ie = '0; ie.sp = 1'b1; ie.mw = 1'b1; ie.data1 = 16'h3333;
    sp = 32'd10;
    #1;
    chk("push_spout", sp_out, 32'd9);
    edge_wait();
    chk("push_addr", em.address, 32'd10);
    chk("push_mw", em.mw, 1'b1);

    @(negedge clk);
    ie = '0; ie.sp = 1'b1; ie.spop = 1'b1; ie.mr = 1'b1;
    ie.stack_flags = 1'b1; ie.stack_pc = 1'b1;
    ie.pc = 32'h1234_5678; ffm = 3'b101;
    #1;
    chk("pop_spout", sp_out, 32'd11);
    edge_wait();
    chk("pop_addr", em.address, 32'd11);
    chk("pop_data", em.data, 32'h1234_5678);
    chk("pop_flags", flags, 3'b101);
    chk("pop_ff", em.final_flags, 3'b101);
    chk("pop_spc", em.stack_pc, 1'b1);
    chk("pop_sfl", em.stack_flags, 1'b1);

    @(negedge clk); ie = '0; ie.data1 = 16'hABCD;
    #1;
    chk("nosp_spout", sp_out, 32'd10);
    edge_wait();
    chk("nosp_addr", em.address, 32'h0000_ABCD);
    chk("nosp_flags", flags, 3'b101);

    // Jumps
    @(negedge clk); alu_op(1'b0, OP_SUB, 16'd5, 16'd5);
    edge_wait();
    chk("sub0_flags", flags, 3'b001);

    @(negedge clk);
    ie = '0; ie.jmp = 1'b1; ie.fgs = FGS_ZF;
    ie.data1 = 16'h0040; ie.jwsp = 1'b1;
    #1;
    chk("jz_taken", tj, 1'b1);
    chk("jz_pcsel", tpc, 1'b1);
    edge_wait();
    chk("jz_data", em.data, 32'h40);
    chk("jz_jwsp", em.jwsp, 1'b1);
    chk("jz_flags", flags, 3'b000);

    @(negedge clk);
    ie = '0; ie.jmp = 1'b1; ie.fgs = FGS_ZF;
    #1;
    chk("jz_not", tj, 1'b0);

    @(negedge clk);
    ie = '0; ie.jmp = 1'b1; ie.fgs = FGS_ALW;
    #1;
    chk("jmp_alw", tj, 1'b1);
    edge_wait();
    chk("jalw_flags", flags, 3'b000);

    @(negedge clk); ie = '0; ie.fd = FD_SETC;
    edge_wait();
    chk("setc2_flags", flags, 3'b010);

    @(negedge clk);
    ie = '0; ie.jmp = 1'b1; ie.fgs = FGS_CF;
    #1;
    chk("jc_taken", tj, 1'b1);
    edge_wait();
    chk("jc_flags", flags, 3'b000);

    @(negedge clk);
    ie = '0; ie.jmp = 1'b1; ie.fgs = FGS_NF;
    #1;
    chk("jn_not", tj, 1'b0);

    @(negedge clk); alu_op(1'b1, OP_NOT, 16'd0, 16'd0);
    edge_wait();
    chk("not0_flags", flags, 3'b100);

    @(negedge clk);
    ie = '0; ie.jmp = 1'b1; ie.fgs = FGS_NF; ie.data1 = 16'h0099;
    #1;
    chk("jn_taken", tj, 1'b1);
    edge_wait();
    chk("jn_flags", flags, 3'b000);

    @(negedge clk); alu_op(1'b1, OP_NOT, 16'd0, 16'd0);
    edge_wait();
    chk("not0b_flags", flags, 3'b100);

    // Asynchronous reset between edges
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_exmem", em_w, 76'd0);
    chk("arst_flags", flags, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
